// File: rtl/game_status_pkg.sv
// ---------------------------------------------------------------------------
// game_status_pkg
// Shared types and constants for the game status tracker.
//   state_e     : tracker FSM states (idle, playing, terminal done)
//   LIVES_W     : width of the lives counter
//   ALIENS_W    : width of the aliens-remaining counter
//   *_DEF       : default values for the tracker parameters
// ---------------------------------------------------------------------------
package game_status_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int LIVES_W  = 3;
  localparam int ALIENS_W = 6;

  localparam int ALIEN_COUNT_DEF     = 30;
  localparam int START_LIVES_DEF     = 3;
  localparam int MAX_LIVES_DEF       = 7;
  localparam int SCORE_PER_ALIEN_DEF = 10;
  localparam int SCORE_W_DEF         = 12;
  localparam int BONUS_SCORE_DEF     = 200;

endpackage

// File: rtl/rise_edge_pulse.sv
// ---------------------------------------------------------------------------
// rise_edge_pulse
// Rising-edge detector. The previous input level is held in a flop; the
// pulse is high for the single cycle in which din is 1 and was 0 in the
// cycle before. The consumer registers the pulse, so the combined latency
// from the input edge to a registered output is one cycle.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset (previous level cleared to 0)
//   din   : level input, already synchronous to clk
//   pulse : one-cycle rising-edge indication
// ---------------------------------------------------------------------------
module rise_edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign pulse = din & ~prev_q;

endmodule

// File: rtl/game_status_tracker.sv
// ---------------------------------------------------------------------------
// game_status_tracker
// Turns raw gameplay events into start/lost/win pulses for the mode selector
// and keeps the lives, aliens-remaining and score counters for the HUD.
// Optional feature macro: GAME_STATUS_BONUS_LIFE_EN (bonus life each time
// the score crosses a multiple of BONUS_SCORE, capped at MAX_LIVES).
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   startKey           : keypad start level (synchronised)
//   alienHitPulse      : one-cycle pulse per alien destroyed
//   playerHitPulse     : one-cycle pulse per player hit
//   alienReachedBottom : level, an alien touched the player row
//   startGamePulse     : registered one-cycle game start pulse
//   lostGamePulse      : registered one-cycle game lost pulse
//   winGamePulse       : registered one-cycle game won pulse
//   lives, aliensLeft, score : registered HUD counters
// ---------------------------------------------------------------------------
module game_status_tracker
  import game_status_pkg::*;
#(
  parameter int ALIEN_COUNT     = ALIEN_COUNT_DEF,
  parameter int START_LIVES     = START_LIVES_DEF,
  parameter int MAX_LIVES       = MAX_LIVES_DEF,
  parameter int SCORE_PER_ALIEN = SCORE_PER_ALIEN_DEF,
  parameter int SCORE_W         = SCORE_W_DEF,
  parameter int BONUS_SCORE     = BONUS_SCORE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                startKey,
  input  logic                alienHitPulse,
  input  logic                playerHitPulse,
  input  logic                alienReachedBottom,
  output logic                startGamePulse,
  output logic                lostGamePulse,
  output logic                winGamePulse,
  output logic [LIVES_W-1:0]  lives,
  output logic [ALIENS_W-1:0] aliensLeft,
  output logic [SCORE_W-1:0]  score
);

  state_e              state_q, state_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic [ALIENS_W-1:0] aliens_q, aliens_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                start_p_q, start_p_d;
  logic                lost_p_q, lost_p_d;
  logic                win_p_q, win_p_d;

  logic                start_rise;
  logic                kill;
  logic [ALIENS_W-1:0] aliens_upd;
  logic [SCORE_W-1:0]  score_upd;
  logic [LIVES_W-1:0]  lives_upd;
  logic                loss;
  logic                win;

  function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] a);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + (SCORE_W+1)'(SCORE_PER_ALIEN);
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  rise_edge_pulse u_start_edge (
    .clk   (clk),
    .reset (reset),
    .din   (startKey),
    .pulse (start_rise)
  );

  // A kill with no aliens left is dropped entirely (no score either).
  assign kill       = alienHitPulse && (aliens_q != '0);
  assign aliens_upd = kill ? aliens_q - ALIENS_W'(1) : aliens_q;
  assign score_upd  = kill ? sat_add_score(score_q) : score_q;

`ifdef GAME_STATUS_BONUS_LIFE_EN
  logic bonus;
  assign bonus = (32'(score_upd) / BONUS_SCORE) != (32'(score_q) / BONUS_SCORE);
`else
  logic unused_bonus_score;
  assign unused_bonus_score = ^BONUS_SCORE;
`endif

  // Hit is applied before the bonus so that hit+bonus is a net zero even at
  // the MAX_LIVES ceiling, and a bonus at one life cancels the fatal hit.
  always_comb begin
    lives_upd = lives_q;
    if (playerHitPulse && (lives_q != '0)) begin
      lives_upd = lives_q - LIVES_W'(1);
    end
`ifdef GAME_STATUS_BONUS_LIFE_EN
    if (bonus && (lives_upd < LIVES_W'(MAX_LIVES))) begin
      lives_upd = lives_upd + LIVES_W'(1);
    end
`endif
  end

  // The bottom detector is taken as a level: a contact already present when
  // play begins must still end the game, and S_DONE being terminal is what
  // limits a long level to a single lostGamePulse.
  assign loss = alienReachedBottom || ((lives_q != '0) && (lives_upd == '0));
  assign win  = (aliens_q != '0) && (aliens_upd == '0);

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    aliens_d  = aliens_q;
    score_d   = score_q;
    start_p_d = 1'b0;
    lost_p_d  = 1'b0;
    win_p_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d   = S_PLAY;
          lives_d   = LIVES_W'(START_LIVES);
          aliens_d  = ALIENS_W'(ALIEN_COUNT);
          score_d   = '0;
          start_p_d = 1'b1;
        end
      end
      S_PLAY: begin
        lives_d  = lives_upd;
        aliens_d = aliens_upd;
        score_d  = score_upd;
        // Loss has priority over a same-cycle win.
        if (loss) begin
          lost_p_d = 1'b1;
          state_d  = S_DONE;
        end else if (win) begin
          win_p_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lives_q   <= '0;
      aliens_q  <= '0;
      score_q   <= '0;
      start_p_q <= 1'b0;
      lost_p_q  <= 1'b0;
      win_p_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      aliens_q  <= aliens_d;
      score_q   <= score_d;
      start_p_q <= start_p_d;
      lost_p_q  <= lost_p_d;
      win_p_q   <= win_p_d;
    end
  end

  assign startGamePulse = start_p_q;
  assign lostGamePulse  = lost_p_q;
  assign winGamePulse   = win_p_q;
  assign lives          = lives_q;
  assign aliensLeft     = aliens_q;
  assign score          = score_q;

endmodule

// File: tb/tb_game_status_tracker.sv
// ---------------------------------------------------------------------------
// tb_game_status_tracker
// Directed game scenarios followed by randomized play, every cycle compared
// against a game-rules reference model. Build with GAME_STATUS_BONUS_LIFE_EN
// defined to exercise the bonus-life feature.
// ---------------------------------------------------------------------------
module tb_game_status_tracker;

  localparam int N_ALIENS  = 30;
  localparam int N_LIVES   = 3;
  localparam int LIVES_MAX = 7;
  localparam int PTS       = 10;
  localparam int SCORE_MAX = 4095;
  localparam int BONUS_AT  = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startKey = 1'b0;
  logic        alienHitPulse = 1'b0;
  logic        playerHitPulse = 1'b0;
  logic        alienReachedBottom = 1'b0;
  logic        startGamePulse;
  logic        lostGamePulse;
  logic        winGamePulse;
  logic [2:0]  lives;
  logic [5:0]  aliensLeft;
  logic [11:0] score;

  int checks = 0;
  int failures = 0;

  // Reference model: game-level view (started / over flags, plain integers).
  bit m_started, m_over, m_prev_key;
  int m_lives, m_aliens, m_score;
  bit e_start, e_lost, e_win;
  int n_start, n_lost, n_win;

  game_status_tracker dut (
    .clk                (clk),
    .reset              (reset),
    .startKey           (startKey),
    .alienHitPulse      (alienHitPulse),
    .playerHitPulse     (playerHitPulse),
    .alienReachedBottom (alienReachedBottom),
    .startGamePulse     (startGamePulse),
    .lostGamePulse      (lostGamePulse),
    .winGamePulse       (winGamePulse),
    .lives              (lives),
    .aliensLeft         (aliensLeft),
    .score              (score)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit r, input bit s, input bit ah, input bit ph, input bit bot);
    bit rise, lost, won;
    int nl, na, ns;
    rise = s && !m_prev_key;
    m_prev_key = s;
    e_start = 0; e_lost = 0; e_win = 0;
    if (r) begin
      m_started = 0; m_over = 0; m_prev_key = 0;
      m_lives = 0; m_aliens = 0; m_score = 0;
    end else if (!m_started) begin
      if (rise) begin
        m_started = 1;
        m_lives = N_LIVES; m_aliens = N_ALIENS; m_score = 0;
        e_start = 1;
      end
    end else if (!m_over) begin
      na = m_aliens; ns = m_score; nl = m_lives;
      if (ah && m_aliens > 0) begin
        na = m_aliens - 1;
        ns = (m_score + PTS > SCORE_MAX) ? SCORE_MAX : m_score + PTS;
      end
      if (ph && nl > 0) nl = nl - 1;
`ifdef GAME_STATUS_BONUS_LIFE_EN
      if (ns / BONUS_AT > m_score / BONUS_AT) nl = (nl + 1 > LIVES_MAX) ? LIVES_MAX : nl + 1;
`endif
      lost = bot || (m_lives > 0 && nl == 0);
      won  = (m_aliens > 0 && na == 0);
      m_lives = nl; m_aliens = na; m_score = ns;
      if (lost) begin
        e_lost = 1; m_over = 1;
      end else if (won) begin
        e_win = 1; m_over = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("startGamePulse", 32'(startGamePulse), 32'(e_start));
    chk("lostGamePulse", 32'(lostGamePulse), 32'(e_lost));
    chk("winGamePulse", 32'(winGamePulse), 32'(e_win));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("aliensLeft", 32'(aliensLeft), 32'(m_aliens));
    chk("score", 32'(score), 32'(m_score));
    chk("pulse_exclusive", 32'(startGamePulse + lostGamePulse + winGamePulse) <= 1 ? 32'd1 : 32'd0, 32'd1);
    if (startGamePulse) n_start++;
    if (lostGamePulse) n_lost++;
    if (winGamePulse) n_win++;
  endtask

  // One clock cycle with the given inputs; outputs checked 1 time unit
  // after the active edge.
  task automatic cyc(input bit r, input bit s, input bit ah, input bit ph, input bit bot);
    reset = r; startKey = s; alienHitPulse = ah; playerHitPulse = ph; alienReachedBottom = bot;
    @(posedge clk);
    model_step(r, s, ah, ph, bot);
    #1;
    check_all();
  endtask

  // Reset then a clean start edge; leaves the game in play with key held high.
  task automatic new_game();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("start_pulse_seen", 32'(startGamePulse), 32'd1);
    chk("start_lives", 32'(lives), N_LIVES);
    chk("start_aliens", 32'(aliensLeft), N_ALIENS);
  endtask

  initial begin
    m_started = 0; m_over = 0; m_prev_key = 0;
    m_lives = 0; m_aliens = 0; m_score = 0;
    n_start = 0; n_lost = 0; n_win = 0;

    // Reset state, then start edge at cycle 5 with the key held high.
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 0);
    chk("reset_lives", 32'(lives), 0);
    chk("reset_score", 32'(score), 0);
    for (int i = 2; i < 5; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("tp_start_pulse", 32'(startGamePulse), 32'd1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    chk("tp_single_start", 32'(n_start), 32'd1);

    // 30 kills two cycles apart, then a 31st kill.
    for (int i = 0; i < 30; i++) begin
      cyc(0, 1, 1, 0, 0);
      cyc(0, 1, 0, 0, 0);
    end
    chk("tp_win_count", 32'(n_win), 32'd1);
    chk("tp_final_score", 32'(score), 32'd300);
    chk("tp_final_aliens", 32'(aliensLeft), 32'd0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);

    // Three player hits, then ignored hits and starts.
    new_game();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 1, 0);
      cyc(0, 1, 0, 0, 0);
    end
    chk("tp_lost_count", 32'(n_lost), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 1, 0);
      cyc(0, 1, 0, 0, 1);
    end
    chk("tp_lost_once", 32'(n_lost), 32'd1);

    // Last alien killed together with bottom contact: loss wins.
    new_game();
    for (int i = 0; i < 29; i++) cyc(0, 1, 1, 0, 0);
    chk("tp_one_left", 32'(aliensLeft), 32'd1);
    cyc(0, 1, 1, 0, 1);
    chk("tp_tie_lost", 32'(lostGamePulse), 32'd1);
    chk("tp_tie_nowin", 32'(winGamePulse), 32'd0);

    // Bottom contact held long: one loss only.
    new_game();
    n_lost = 0;
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 1);
    chk("tp_bottom_once", 32'(n_lost), 32'd1);

    // Mid-game reset at score 120, then a reload.
    new_game();
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0);
    chk("tp_score_120", 32'(score), 32'd120);
    cyc(1, 1, 1, 1, 0);
    chk("tp_reset_score", 32'(score), 32'd0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("tp_reload_aliens", 32'(aliensLeft), N_ALIENS);

    // Bonus boundary: 20 kills, then 19 kills plus a kill with a player hit.
    new_game();
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, 0);
`ifdef GAME_STATUS_BONUS_LIFE_EN
    chk("tp_bonus_life", 32'(lives), 32'd4);
`else
    chk("tp_no_bonus", 32'(lives), 32'd3);
`endif
    new_game();
    for (int i = 0; i < 19; i++) cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
`ifdef GAME_STATUS_BONUS_LIFE_EN
    chk("tp_bonus_hit", 32'(lives), 32'd3);
`else
    chk("tp_hit_no_bonus", 32'(lives), 32'd2);
`endif

    // Randomized games.
    for (int g = 0; g < 25; g++) begin
      bit key;
      key = 0;
      cyc(1, 0, 0, 0, 0);
      for (int c = 0; c < 160; c++) begin
        if ($urandom_range(0, 99) < 8) key = ~key;
        cyc(($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0, key,
            ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(0, 999) < 8) ? 1'b1 : 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
